// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions: flag bit positions, branch condition codes
// and the branch sequencer state encoding.
package arch_defs_pkg;

   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_V = 3;

   typedef enum logic [3:0] {
      COND_ALWAYS = 4'd0,
      COND_Z      = 4'd1,
      COND_NZ     = 4'd2,
      COND_N      = 4'd3,
      COND_NN     = 4'd4,
      COND_C      = 4'd5,
      COND_NC     = 4'd6,
      COND_V      = 4'd7,
      COND_NV     = 4'd8
   } cond_code_t;

   typedef enum logic [1:0] {
      StIdle,
      StFetchLo,
      StFetchHi,
      StExec
   } branch_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: condition code plus flag snapshot
// gives the taken decision. Codes 9-15 are reserved and never taken.
module branch_cond_eval
   import arch_defs_pkg::*;
#(
   parameter int unsigned NUM_FLAGS = 4
) (
   input  logic [3:0]           cond_sel_i,
   input  logic [NUM_FLAGS-1:0] flags_i,
   output logic                 taken_o
);

   always_comb begin
      taken_o = 1'b0;
      case (cond_code_t'(cond_sel_i))
         COND_ALWAYS: taken_o = 1'b1;
         COND_Z:      taken_o = flags_i[FLAG_Z];
         COND_NZ:     taken_o = ~flags_i[FLAG_Z];
         COND_N:      taken_o = flags_i[FLAG_N];
         COND_NN:     taken_o = ~flags_i[FLAG_N];
         COND_C:      taken_o = flags_i[FLAG_C];
         COND_NC:     taken_o = ~flags_i[FLAG_C];
         COND_V:      taken_o = flags_i[FLAG_V];
         COND_NV:     taken_o = ~flags_i[FLAG_V];
         default:     taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_sequencer.sv
// Program counter owner and branch executor: fetches one or two operand bytes,
// evaluates the latched condition and loads an absolute or PC-relative target.
module branch_sequencer
   import arch_defs_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH   = 16,
   parameter int unsigned           DATA_WIDTH   = 8,
   parameter int unsigned           NUM_FLAGS    = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hF000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [3:0]            cond_sel,
   input  logic                  rel_mode,
   input  logic [NUM_FLAGS-1:0]  flags_i,
   input  logic                  pc_inc_i,
   input  logic [DATA_WIDTH-1:0] mem_data_i,
   input  logic                  mem_valid_i,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  taken_o
);

   localparam logic [ADDR_WIDTH-1:0] PcOne = ADDR_WIDTH'(1);

   branch_state_t         state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [3:0]            cond_q, cond_d;
   logic                  rel_q, rel_d;
   logic [NUM_FLAGS-1:0]  flags_q, flags_d;
   logic [DATA_WIDTH-1:0] temp_lo_q, temp_lo_d;
   logic [DATA_WIDTH-1:0] temp_hi_q, temp_hi_d;
   logic                  mem_req_q, mem_req_d;
   logic                  done_q, done_d;
   logic                  taken_q, taken_d;
   logic                  cond_taken;
   logic [ADDR_WIDTH-1:0] rel_offset;
   logic [ADDR_WIDTH-1:0] abs_target;

   branch_cond_eval #(
      .NUM_FLAGS (NUM_FLAGS)
   ) u_cond_eval (
      .cond_sel_i (cond_q),
      .flags_i    (flags_q),
      .taken_o    (cond_taken)
   );

   assign rel_offset = {{(ADDR_WIDTH-DATA_WIDTH){temp_lo_q[DATA_WIDTH-1]}}, temp_lo_q};
   assign abs_target = ADDR_WIDTH'({temp_hi_q, temp_lo_q});

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      cond_d    = cond_q;
      rel_d     = rel_q;
      flags_d   = flags_q;
      temp_lo_d = temp_lo_q;
      temp_hi_d = temp_hi_q;
      done_d    = 1'b0;
      taken_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            // start has priority: the PC already points at the first operand
            if (start) begin
               cond_d  = cond_sel;
               rel_d   = rel_mode;
               flags_d = flags_i;
               state_d = StFetchLo;
            end else if (pc_inc_i) begin
               pc_d = pc_q + PcOne;
            end
         end
         StFetchLo: begin
            if (mem_valid_i) begin
               temp_lo_d = mem_data_i;
               pc_d      = pc_q + PcOne;
               state_d   = rel_q ? StExec : StFetchHi;
            end
         end
         StFetchHi: begin
            if (mem_valid_i) begin
               temp_hi_d = mem_data_i;
               pc_d      = pc_q + PcOne;
               state_d   = StExec;
            end
         end
         StExec: begin
            if (cond_taken) begin
               pc_d = rel_q ? (pc_q + rel_offset) : abs_target;
            end
            done_d  = 1'b1;
            taken_d = cond_taken;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      mem_req_d = (state_d == StFetchLo) || (state_d == StFetchHi);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         pc_q      <= RESET_VECTOR;
         cond_q    <= '0;
         rel_q     <= 1'b0;
         flags_q   <= '0;
         temp_lo_q <= '0;
         temp_hi_q <= '0;
         mem_req_q <= 1'b0;
         done_q    <= 1'b0;
         taken_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         cond_q    <= cond_d;
         rel_q     <= rel_d;
         flags_q   <= flags_d;
         temp_lo_q <= temp_lo_d;
         temp_hi_q <= temp_hi_d;
         mem_req_q <= mem_req_d;
         done_q    <= done_d;
         taken_q   <= taken_d;
      end
   end

   assign mem_req_o = mem_req_q;
   assign pc_o      = pc_q;
   assign busy_o    = (state_q != StIdle);
   assign done_o    = done_q;
   assign taken_o   = taken_q;

endmodule
